// File: rtl/fa_response_checker.sv
// Scoreboard for a 1-bit full adder: scores sampled {carry_in, x, y} -> {sum, carry_out}
// pairs against the reference equations, tracks vector coverage and reports a verdict.
module fa_response_checker #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             x,
  input  logic             y,
  input  logic             carry_in,
  input  logic             sum,
  input  logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       coverage,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [TMO_W-1:0]   run_cnt;
  logic [2:0]         vec_idx;
  logic               exp_sum, exp_cout, match, mismatch;
  logic [7:0]         cov_upd;
  logic [CNT_W-1:0]   err_upd;
  logic               cov_full, run_expired;

  assign vec_idx = {carry_in, x, y};

  // Anything other than a clean 1 on match (including X/Z) is scored as a mismatch.
  always_comb begin
    exp_sum  = x ^ y ^ carry_in;
    exp_cout = (x & y) | (carry_in & (x ^ y));
    match    = (sum == exp_sum) && (carry_out == exp_cout);
    mismatch = (match !== 1'b1);
    cov_upd  = coverage;
    err_upd  = err_count;
    if (sample_valid) begin
      cov_upd[vec_idx] = 1'b1;
      if (mismatch && (err_count != '1))
        err_upd = err_count + 1'b1;
    end
    cov_full    = (cov_upd == 8'hFF);
    run_expired = (run_cnt == TMO_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cov_full || run_expired) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt          <= '0;
      pass             <= 1'b0;
      timeout          <= 1'b0;
      err_count        <= '0;
      coverage         <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          run_cnt   <= run_cnt + 1'b1;
          coverage  <= cov_upd;
          err_count <= err_upd;
          if (sample_valid && mismatch && !first_fail_valid) begin
            first_fail_vec   <= vec_idx;
            first_fail_valid <= 1'b1;
          end
          // Completion takes priority over an abort landing on the same edge.
          if (cov_full) begin
            pass    <= (err_upd == '0);
            timeout <= 1'b0;
          end else if (run_expired) begin
            pass    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            run_cnt          <= '0;
            pass             <= 1'b0;
            timeout          <= 1'b0;
            err_count        <= '0;
            coverage         <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench for fa_response_checker: table of full sweeps plus hand-written
// sequences for timeout, mid-run reset and gapped sampling.
module tb_fa_response_checker;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 64;
  localparam int TMO_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n, start, sample_valid, x, y, carry_in, sum, carry_out;
  logic             busy, done, pass, timeout, first_fail_valid;
  logic [CNT_W-1:0] err_count;
  logic [7:0]       coverage;
  logic [2:0]       first_fail_vec;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] sum_mask;
    logic [7:0] cout_mask;
    bit         rev;
    bit         exp_pass;
    int         exp_err;
    logic [2:0] exp_ffv;
    bit         exp_ffvalid;
  } sweep_t;

  sweep_t tbl[5];

  fa_response_checker #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .x(x), .y(y), .carry_in(carry_in), .sum(sum), .carry_out(carry_out),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .coverage(coverage),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] idx, input bit v, input bit sflip, input bit cflip);
    logic a, b, c;
    {c, a, b} = idx;
    carry_in     = c;
    x            = a;
    y            = b;
    sum          = (a ^ b ^ c) ^ sflip;
    carry_out    = ((a & b) | (c & (a ^ b))) ^ cflip;
    sample_valid = v;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_cov"}, coverage, 0);
    chk({tag, "_ffv"}, first_fail_vec, 0);
    chk({tag, "_ffvalid"}, first_fail_valid, 0);
  endtask

  initial begin
    tbl[0] = '{8'h00, 8'h00, 1'b0, 1'b1, 0, 3'd0, 1'b0};
    tbl[1] = '{8'h04, 8'h00, 1'b0, 1'b0, 1, 3'd2, 1'b1};
    tbl[2] = '{8'h00, 8'hFF, 1'b0, 1'b0, 8, 3'd0, 1'b1};
    tbl[3] = '{8'hA0, 8'h20, 1'b0, 1'b0, 2, 3'd5, 1'b1};
    tbl[4] = '{8'h09, 8'h00, 1'b1, 1'b0, 2, 3'd3, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) begin
      pulse_start();
      chk($sformatf("t%0d_busy_start", t), busy, 1);
      chk($sformatf("t%0d_err_clear", t), err_count, 0);
      chk($sformatf("t%0d_cov_clear", t), coverage, 0);
      for (int i = 0; i < 8; i++) begin
        logic [2:0] idx;
        idx = tbl[t].rev ? 3'(7 - i) : 3'(i);
        drive(idx, 1'b1, tbl[t].sum_mask[idx], tbl[t].cout_mask[idx]);
        tick();
        if (i == 6) begin
          chk($sformatf("t%0d_busy7", t), busy, 1);
          chk($sformatf("t%0d_done7", t), done, 0);
        end
      end
      sample_valid = 1'b0;
      chk($sformatf("t%0d_done", t), done, 1);
      chk($sformatf("t%0d_busy", t), busy, 0);
      chk($sformatf("t%0d_pass", t), pass, tbl[t].exp_pass);
      chk($sformatf("t%0d_err", t), err_count, tbl[t].exp_err);
      chk($sformatf("t%0d_cov", t), coverage, 8'hFF);
      chk($sformatf("t%0d_timeout", t), timeout, 0);
      chk($sformatf("t%0d_ffv", t), first_fail_vec, tbl[t].exp_ffv);
      chk($sformatf("t%0d_ffvalid", t), first_fail_valid, tbl[t].exp_ffvalid);
    end

    // DONE holds and ignores samples
    drive(3'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("done_hold", done, 1);
    chk("done_err_hold", err_count, 2);

    // Gapped clean sweep from a failed DONE
    chk("alt_prev_pass", pass, 0);
    pulse_start();
    chk("alt_err_clear", err_count, 0);
    chk("alt_cov_clear", coverage, 0);
    chk("alt_ffvalid_clear", first_fail_valid, 0);
    chk("alt_pass_clear", pass, 0);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) drive(3'(i / 2), 1'b1, 1'b0, 1'b0);
      else            drive(3'(i / 2), 1'b0, 1'b1, 1'b1);
      tick();
    end
    sample_valid = 1'b0;
    chk("alt_done", done, 1);
    chk("alt_pass", pass, 1);
    chk("alt_err", err_count, 0);
    chk("alt_cov", coverage, 8'hFF);

    // Timeout: only vectors 0..6 applied
    begin
      int n;
      n = 0;
      pulse_start();
      while (done !== 1'b1 && n < 200) begin
        drive(3'(n % 7), 1'b1, 1'b0, 1'b0);
        tick();
        n++;
      end
      sample_valid = 1'b0;
      chk("tmo_cycles", n, TIMEOUT);
      chk("tmo_done", done, 1);
      chk("tmo_timeout", timeout, 1);
      chk("tmo_pass", pass, 0);
      chk("tmo_cov", coverage, 8'h7F);
      chk("tmo_err", err_count, 0);
    end

    // Mid-run reset
    pulse_start();
    drive(3'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(3'd1, 1'b1, 1'b1, 1'b0); tick();
    drive(3'd2, 1'b1, 1'b0, 1'b0); tick();
    chk("mid_err_before", err_count, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    drive(3'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("idle_ignore_cov", coverage, 0);
    chk("idle_busy", busy, 0);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    sample_valid = 1'b0;
    chk("post_rst_done", done, 1);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_err", err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
